alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
Parametrised successor to the combinational ALU-operation decoder. It merges ALUOp/funct decode with a registered execute stage in one block.
- Single-cycle ops (logic, add/sub, inc, mov) complete with latency 1.
- MULTPLUS (A*B + C) runs on an iterative shift-add multiplier.
- A valid/ready handshake stalls the datapath while a multiply is in flight.
- Sits between register-file read and writeback in the multi-cycle MIPS core.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
ALUOP_W, 3, width of ALUOp field from main control
CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
alu_op  in  ALUOP_W  ALUOp from control unit
alu_funct  in  6  instruction funct field
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt or extended immediate)
op_c  in  WIDTH  addend for MULTPLUS
out_valid  out  1  one-cycle pulse; result fields valid
result  out  WIDTH  operation result, modulo 2^WIDTH
zero  out  1  result == 0
illegal  out  1  decoded selector unmatched
alu_operation  out  4  decoded operation code of the accepted op (debug/trace)

Behaviour:
- Reset (async, any time, including mid-multiply):
  - in_ready=1, out_valid=0, result=0, zero=0, illegal=0, alu_operation=0.
  - State goes to IDLE; the in-flight op is discarded with no out_valid.
- Decode, selector {alu_op, alu_funct}, first match wins:
  - 111_100100 AND, code 0000
  - 111_100101 OR, 0001
  - 111_100111 NOR, 0010
  - 111_100000 ADD, 0011
  - 111_100010 SUB, 1000
  - 100_x ADDI (ADD), 0011
  - 101_x ORI (OR), 0001
  - 001_x BEQ/BNE (SUB), 0100
  - 110_x INC (A+1), 0101
  - 011_x MULTPLUS (A*B+C), 0110
  - 010_x MOV (result=B), 0111
  - anything else: code 1001, result=0, illegal=1
- All arithmetic wraps modulo 2^WIDTH; no overflow flag. MULTPLUS keeps the low WIDTH bits of A*B+C.
- Accept = in_valid & in_ready, sampled on the rising edge.
- FSM states IDLE, MUL.
- IDLE, non-MULTPLUS accepted:
  - Result, zero, illegal and alu_operation are registered; out_valid=1 next cycle; stay in IDLE.
  - Back-to-back accepts are allowed, one result per cycle.
- IDLE, MULTPLUS accepted:
  - Latch multiplicand=A, multiplier=B, acc=C, cnt=0; go to MUL; in_ready=0 from the next cycle.
- MUL, each cycle:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1, multiplier >>= 1, cnt++.
  - When cnt reaches WIDTH-1 (the last iteration), register result=acc (including that iteration), assert out_valid next cycle, return to IDLE.
  - Latency from accept to out_valid = WIDTH+1 cycles.
- in_ready = (state==IDLE). Requests while busy are not accepted; the requester holds them.
- out_valid is never held; the consumer must sample it in its pulse cycle. result/zero/illegal/alu_operation hold their last values between pulses.
- zero is computed on the final result, including MULTPLUS.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: in MUL, if the remaining multiplier == 0 the multiply finishes that cycle, giving variable latency.
  - Minimum is 2 cycles when B==0: the accept cycle detects the zero multiplier, and out_valid follows.
  - Results are identical to the undefined case.
- Undefined: fixed WIDTH+1 latency regardless of operand values.

Test Plan:
- WIDTH=32. Reset, then ADD: op 111, funct 100000, A=0xFFFFFFFF, B=1 -> next cycle out_valid=1, result=0, zero=1, alu_operation=0011.
- Back-to-back NOR (A=0, B=0), INC (A=7), MOV (B=0x55) on consecutive cycles -> three consecutive out_valid pulses: 0xFFFFFFFF, 8, 0x55; in_ready stays 1.
- MULTPLUS A=3, B=5, C=10 -> in_ready low for 32 cycles, out_valid exactly 33 cycles after accept, result=25.
- Illegal selector: op 000, funct 000000 -> out_valid=1, illegal=1, result=0, alu_operation=1001. Then BEQ A=9, B=9 -> result=0, zero=1, code 0100.
- Assert reset 10 cycles into MULTPLUS A=0xFFFF, B=0xFFFF -> no out_valid, in_ready=1, outputs 0. A following ADD 2+2 returns 4 normally.
- With MULT_EARLY_EXIT_EN, MULTPLUS B=0, C=0x1234 -> result=0x1234, out_valid 2 cycles after accept. B=0x80000000 -> full 33-cycle latency.

Source files
------------

// File: rtl/alu_seq_exec.sv
// ALU decode + registered execute stage with an iterative shift-add MULTPLUS (A*B+C).
// Optional macro MULT_EARLY_EXIT_EN: finish a multiply as soon as the remaining multiplier is zero.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         alu_funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   op_c,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic [3:0]         alu_operation
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [ALUOP_W-1:0] OP_RTYPE = ALUOP_W'(3'd7);
  localparam logic [ALUOP_W-1:0] OP_ADDI  = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] OP_ORI   = ALUOP_W'(3'd5);
  localparam logic [ALUOP_W-1:0] OP_BR    = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] OP_INC   = ALUOP_W'(3'd6);
  localparam logic [ALUOP_W-1:0] OP_MULP  = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] OP_MOV   = ALUOP_W'(3'd2);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [3:0]         code_s;
  logic [WIDTH-1:0]   res_s;
  logic               ill_s;
  logic               is_mul_s;
  logic               accept_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic               mul_done_s;
  logic [WIDTH-1:0]   mul_res_s;

  assign accept_s = in_valid & in_ready;

  // Selector decode and single-cycle datapath; first matching pattern wins.
  always_comb begin
    code_s   = 4'b1001;
    res_s    = '0;
    ill_s    = 1'b1;
    is_mul_s = 1'b0;
    if (alu_op == OP_RTYPE) begin
      case (alu_funct)
        6'b100100: begin code_s = 4'b0000; res_s = op_a & op_b;    ill_s = 1'b0; end
        6'b100101: begin code_s = 4'b0001; res_s = op_a | op_b;    ill_s = 1'b0; end
        6'b100111: begin code_s = 4'b0010; res_s = ~(op_a | op_b); ill_s = 1'b0; end
        6'b100000: begin code_s = 4'b0011; res_s = op_a + op_b;    ill_s = 1'b0; end
        6'b100010: begin code_s = 4'b1000; res_s = op_a - op_b;    ill_s = 1'b0; end
        default:   begin code_s = 4'b1001; res_s = '0;             ill_s = 1'b1; end
      endcase
    end else if (alu_op == OP_ADDI) begin
      code_s = 4'b0011; res_s = op_a + op_b; ill_s = 1'b0;
    end else if (alu_op == OP_ORI) begin
      code_s = 4'b0001; res_s = op_a | op_b; ill_s = 1'b0;
    end else if (alu_op == OP_BR) begin
      code_s = 4'b0100; res_s = op_a - op_b; ill_s = 1'b0;
    end else if (alu_op == OP_INC) begin
      code_s = 4'b0101; res_s = op_a + WIDTH'(1'b1); ill_s = 1'b0;
    end else if (alu_op == OP_MULP) begin
      code_s = 4'b0110; res_s = '0; ill_s = 1'b0; is_mul_s = 1'b1;
    end else if (alu_op == OP_MOV) begin
      code_s = 4'b0111; res_s = op_b; ill_s = 1'b0;
    end else begin
      code_s = 4'b1001; res_s = '0; ill_s = 1'b1;
    end
  end

  // One shift-add step and the multiply-completion condition.
  always_comb begin
    acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
`ifdef MULT_EARLY_EXIT_EN
    if (mplier_r == '0) begin
      mul_done_s = 1'b1;
      mul_res_s  = acc_r;
    end else begin
      mul_done_s = (cnt_r == CNT_W'(WIDTH - 1));
      mul_res_s  = acc_next_s;
    end
`else
    mul_done_s = (cnt_r == CNT_W'(WIDTH - 1));
    mul_res_s  = acc_next_s;
`endif
  end

  // Control FSM, multiplier iteration and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      result        <= '0;
      zero          <= 1'b0;
      illegal       <= 1'b0;
      alu_operation <= 4'b0000;
      mcand_r       <= '0;
      mplier_r      <= '0;
      acc_r         <= '0;
      cnt_r         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (is_mul_s) begin
              mcand_r  <= op_a;
              mplier_r <= op_b;
              acc_r    <= op_c;
              cnt_r    <= '0;
              state_r  <= MUL;
              in_ready <= 1'b0;
            end else begin
              result        <= res_s;
              zero          <= (res_s == '0);
              illegal       <= ill_s;
              alu_operation <= code_s;
              out_valid     <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done_s) begin
            result        <= mul_res_s;
            zero          <= (mul_res_s == '0);
            illegal       <= 1'b0;
            alu_operation <= 4'b0110;
            out_valid     <= 1'b1;
            state_r       <= IDLE;
            in_ready      <= 1'b1;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec (WIDTH=32); latency expectations follow MULT_EARLY_EXIT_EN.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [5:0]  alu_funct;
  logic [31:0] op_a, op_b, op_c;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [3:0]  alu_operation;

  int checks = 0;
  int failures = 0;

`ifdef MULT_EARLY_EXIT_EN
  localparam int LAT_35   = 5;
  localparam int LAT_B0   = 2;
`else
  localparam int LAT_35   = 33;
  localparam int LAT_B0   = 33;
`endif
  localparam int LAT_BMSB = 33;

  alu_seq_exec #(.WIDTH(32), .ALUOP_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_funct(alu_funct), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
    .alu_operation(alu_operation)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid = 1'b1; alu_op = op; alu_funct = fn; op_a = a; op_b = b; op_c = c;
  endtask

  // Accept one op, then wait for out_valid; returns latency and in_ready-low cycle count.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         output int lat, output int low);
    drive(3'b011, 6'd0, a, b, c);
    tick();
    in_valid = 1'b0;
    lat = 1;
    low = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) low++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, low, seen;
    reset = 1'b1; in_valid = 1'b0; alu_op = 3'd0; alu_funct = 6'd0;
    op_a = 32'd0; op_b = 32'd0; op_c = 32'd0;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, zero, illegal, 2'b00}, 32'd0);
    check("rst_code", {28'd0, alu_operation}, 32'd0);
    reset = 1'b0;
    tick();

    drive(3'b111, 6'b100000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", result, 32'd0);
    check("add_zero", {31'd0, zero}, 32'd1);
    check("add_code", {28'd0, alu_operation}, 32'h3);

    drive(3'b111, 6'b100111, 32'd0, 32'd0, 32'd0);
    tick();
    check("nor_valid", {31'd0, out_valid}, 32'd1);
    check("nor_result", result, 32'hFFFF_FFFF);
    check("nor_ready", {31'd0, in_ready}, 32'd1);
    drive(3'b110, 6'd0, 32'd7, 32'd0, 32'd0);
    tick();
    check("inc_valid", {31'd0, out_valid}, 32'd1);
    check("inc_result", {result[31:1], result[0]}, 32'd8);
    check("inc_code", {28'd0, alu_operation}, 32'h5);
    drive(3'b010, 6'd0, 32'd0, 32'h55, 32'd0);
    tick();
    in_valid = 1'b0;
    check("mov_valid", {31'd0, out_valid}, 32'd1);
    check("mov_result", result, 32'h55);
    check("mov_code", {28'd0, alu_operation}, 32'h7);
    check("mov_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("pulse_drop", {31'd0, out_valid}, 32'd0);
    check("hold_result", result, 32'h55);

    drive(3'b111, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0);
    tick();
    check("and_result", result, 32'h0F00_0F00);
    drive(3'b111, 6'b100010, 32'd5, 32'd7, 32'd0);
    tick();
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_code", {28'd0, alu_operation}, 32'h8);
    drive(3'b101, 6'd0, 32'hF0, 32'h0F, 32'd0);
    tick();
    check("ori_result", result, 32'hFF);
    check("ori_code", {28'd0, alu_operation}, 32'h1);
    drive(3'b100, 6'b111111, 32'd10, 32'd20, 32'd0);
    tick();
    check("addi_result", result, 32'd30);
    drive(3'b111, 6'b000000, 32'd1, 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    check("rtype_bad_illegal", {31'd0, illegal}, 32'd1);
    check("rtype_bad_code", {28'd0, alu_operation}, 32'h9);

    run_mul(32'd3, 32'd5, 32'd10, lat, low);
    check("mul_latency", lat, LAT_35);
    check("mul_ready_low", low, LAT_35 - 1);
    check("mul_valid", {31'd0, out_valid}, 32'd1);
    check("mul_result", result, 32'd25);
    check("mul_code", {28'd0, alu_operation}, 32'h6);
    check("mul_zero", {31'd0, zero}, 32'd0);
    check("mul_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    check("mul_pulse_drop", {31'd0, out_valid}, 32'd0);

    drive(3'b000, 6'b000000, 32'd3, 32'd4, 32'd0);
    tick();
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_result", result, 32'd0);
    check("ill_code", {28'd0, alu_operation}, 32'h9);
    drive(3'b001, 6'd0, 32'd9, 32'd9, 32'd0);
    tick();
    in_valid = 1'b0;
    check("beq_result", result, 32'd0);
    check("beq_zero", {31'd0, zero}, 32'd1);
    check("beq_code", {28'd0, alu_operation}, 32'h4);
    check("beq_illegal", {31'd0, illegal}, 32'd0);

    drive(3'b011, 6'd0, 32'hFFFF, 32'hFFFF, 32'd0);
    tick();
    in_valid = 1'b0;
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_code", {28'd0, alu_operation}, 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 32'd0);
    drive(3'b111, 6'b100000, 32'd2, 32'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    check("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_add", result, 32'd4);

    run_mul(32'd77, 32'd0, 32'h1234, lat, low);
    check("mulb0_latency", lat, LAT_B0);
    check("mulb0_result", result, 32'h1234);
    tick();
    run_mul(32'd3, 32'h8000_0000, 32'd1, lat, low);
    check("mulmsb_latency", lat, LAT_BMSB);
    check("mulmsb_result", result, 32'h8000_0001);
    tick();
    run_mul(32'h0001_0000, 32'h0001_0000, 32'd0, lat, low);
    check("mulwrap_result", result, 32'd0);
    check("mulwrap_zero", {31'd0, zero}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
